// File: rtl/wb_write_arbiter.sv
// Write-port arbiter for the GPR file: grants one writeback source per cycle.
// Define WB_ARB_RR_EN for round-robin; otherwise fixed priority (req 0 first).
module wb_write_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int REG_FILE_BITS = 5,
   parameter int REG_FILE_SIZE = 32,
   parameter int REG_SIZE      = 32,
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*REG_FILE_BITS-1:0] req_num,
   input  logic [NUM_REQ*REG_SIZE-1:0]  req_value,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rf_we,
   output logic [REG_FILE_BITS-1:0]     rf_write_num,
   output logic [REG_SIZE-1:0]          rf_in_value,
   output logic [REG_FILE_SIZE-1:0]     pending_mask,
   output logic [IW-1:0]                grant_id
);

   logic [IW-1:0]            start;
   logic [IW-1:0]            gnt_idx;
   logic [IW-1:0]            idx;
   logic                     found;
   logic                     accept;
   logic [REG_FILE_BITS-1:0] sel_num;
   logic [REG_SIZE-1:0]      sel_val;
   logic                     we_q;
   logic [REG_FILE_SIZE-1:0] mask_q;

`ifdef WB_ARB_RR_EN
   logic [IW-1:0] rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         if (gnt_idx == IW'(NUM_REQ - 1))
            rr_ptr <= '0;
         else
            rr_ptr <= gnt_idx + 1'b1;
      end
   end

   assign start = rr_ptr;
`else
   assign start = '0;
`endif

   // First valid requester found scanning upward from start, wrapping.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IW'((int'(start) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign accept = found && !rst;

   always_comb begin
      req_ready = '0;
      if (accept)
         req_ready[gnt_idx] = 1'b1;
   end

   assign sel_num = req_num[gnt_idx*REG_FILE_BITS +: REG_FILE_BITS];
   assign sel_val = req_value[gnt_idx*REG_SIZE +: REG_SIZE];

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q         <= 1'b0;
         rf_write_num <= '0;
         rf_in_value  <= '0;
         mask_q       <= '0;
         grant_id     <= '0;
      end else if (accept) begin
         grant_id     <= gnt_idx;
         rf_write_num <= sel_num;
         rf_in_value  <= sel_val;
         we_q         <= (sel_num != '0);
         if (sel_num != '0)
            mask_q <= REG_FILE_SIZE'(1) << sel_num;
         else
            mask_q <= '0;
      end else begin
         we_q   <= 1'b0;
         mask_q <= '0;
      end
   end

   // Reset kills the staged write before the register file's negedge capture.
   assign rf_we        = we_q && !rst;
   assign pending_mask = rst ? '0 : mask_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter (NUM_REQ=3), both arbitration builds.
module tb_wb_write_arbiter;
   localparam int N  = 3;
   localparam int RB = 5;
   localparam int RS = 32;
   localparam int RF = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*RB-1:0] req_num;
   logic [N*RS-1:0] req_value;
   logic [N-1:0]    req_ready;
   logic            rf_we;
   logic [RB-1:0]   rf_write_num;
   logic [RS-1:0]   rf_in_value;
   logic [RF-1:0]   pending_mask;
   logic [IW-1:0]   grant_id;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [RS-1:0] rf [RF] = '{default: '0};

   wb_write_arbiter #(
      .NUM_REQ(N), .REG_FILE_BITS(RB), .REG_FILE_SIZE(RF), .REG_SIZE(RS)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_num(req_num), .req_value(req_value),
      .req_ready(req_ready),
      .rf_we(rf_we), .rf_write_num(rf_write_num), .rf_in_value(rf_in_value),
      .pending_mask(pending_mask), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Register file: captures at the negedge inside the write cycle.
   always @(negedge clk)
      if (rf_we && rf_write_num != 0)
         rf[rf_write_num] <= rf_in_value;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic int start_ptr(input int p);
`ifdef WB_ARB_RR_EN
      return p;
`else
      return 0 * p;
`endif
   endfunction

   // Model of the output stage: what the last posedge must have produced.
   int            m_ptr = 0;
   bit            m_we  = 1'b0;
   logic [RB-1:0] m_num = '0;
   logic [RS-1:0] m_val = '0;
   int            m_gid = 0;

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_ptr = 0; m_we = 1'b0; m_num = '0; m_val = '0; m_gid = 0;
      end else begin
         g = pick(req_valid, start_ptr(m_ptr));
         if (g >= 0) begin
            m_gid = g;
            m_ptr = (g + 1) % N;
            m_num = req_num[g*RB +: RB];
            m_val = req_value[g*RS +: RS];
            m_we  = (m_num != 0);
         end else begin
            m_we = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] er;
      int           g;
      bit           ew;
      if (chk_en) begin
         er = '0;
         g  = pick(req_valid, start_ptr(m_ptr));
         if (!rst && g >= 0) er[g] = 1'b1;
         ew = m_we && !rst;
         chk("req_ready", 64'(req_ready), 64'(er));
         chk("rf_we", 64'(rf_we), 64'(ew));
         if (ew) begin
            chk("rf_write_num", 64'(rf_write_num), 64'(m_num));
            chk("rf_in_value", 64'(rf_in_value), 64'(m_val));
         end
         chk("pending_mask", 64'(pending_mask), ew ? (64'd1 << m_num) : 64'd0);
         chk("grant_id", 64'(grant_id), 64'(m_gid));
      end
   end

   task automatic set_req(input int i, input bit v, input logic [RB-1:0] n,
                          input logic [RS-1:0] d);
      req_valid[i]          = v;
      req_num[i*RB +: RB]   = n;
      req_value[i*RS +: RS] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int gseq [6];
   int exp_seq [6];

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_num   = '0;
      req_value = '0;

      // Reset held two cycles with every requester valid.
      set_req(0, 1, 5'd1, 32'h100);
      set_req(1, 1, 5'd2, 32'h200);
      set_req(2, 1, 5'd3, 32'h300);
      step();
      chk_en = 1'b1;
      chk("rst_ready0", 64'(req_ready), 64'd0);
      chk("rst_we0", 64'(rf_we), 64'd0);
      chk("rst_mask0", 64'(pending_mask), 64'd0);
      step();
      chk("rst_ready1", 64'(req_ready), 64'd0);
      chk("rst_we1", 64'(rf_we), 64'd0);
      chk("rst_gid", 64'(grant_id), 64'd0);
      rst = 1'b0;
      #1;
      chk("first_ready", 64'(req_ready), 64'b001);
      step();
      req_valid = '0;
      chk("first_gid", 64'(grant_id), 64'd0);
      chk("first_we", 64'(rf_we), 64'd1);
      chk("first_num", 64'(rf_write_num), 64'd1);
      step();

      // Single write x5 from requester 1.
      set_req(1, 1, 5'd5, 32'hDEADBEEF);
      #1;
      chk("single_ready", 64'(req_ready), 64'b010);
      step();
      set_req(1, 0, 5'd0, 32'h0);
      chk("single_we", 64'(rf_we), 64'd1);
      chk("single_num", 64'(rf_write_num), 64'd5);
      chk("single_val", 64'(rf_in_value), 64'hDEADBEEF);
      chk("single_mask", 64'(pending_mask), 64'h20);
      step();
      chk("single_read_x5", 64'(rf[5]), 64'hDEADBEEF);

      // Contention from rr_ptr=0, all valid for 6 cycles.
      reset_pulse();
      set_req(0, 1, 5'd10, 32'hA0);
      set_req(1, 1, 5'd11, 32'hA1);
      set_req(2, 1, 5'd12, 32'hA2);
      for (int c = 0; c < 6; c++) begin
         #1;
         gseq[c] = -1;
         for (int b = 0; b < N; b++)
            if (req_ready[b]) gseq[c] = b;
`ifdef WB_ARB_RR_EN
         exp_seq[c] = c % 3;
`else
         exp_seq[c] = 0;
`endif
         step();
      end
      req_valid = '0;
      for (int c = 0; c < 6; c++)
         chk($sformatf("grant_seq[%0d]", c), 64'(gseq[c]), 64'(exp_seq[c]));
      step();

      // Write to x0 is consumed but dropped.
      set_req(2, 1, 5'd0, 32'h1234);
      #1;
      chk("x0_ready", 64'(req_ready), 64'b100);
      step();
      req_valid = '0;
      chk("x0_we", 64'(rf_we), 64'd0);
      chk("x0_mask", 64'(pending_mask), 64'd0);
      chk("x0_gid", 64'(grant_id), 64'd2);
      step();

      // Two requesters target x7; the later grant wins.
      reset_pulse();
      set_req(0, 1, 5'd7, 32'h11);
      set_req(1, 1, 5'd7, 32'h22);
      #1;
      chk("dup_ready0", 64'(req_ready), 64'b001);
      step();
      set_req(0, 0, 5'd0, 32'h0);
      chk("dup_val0", 64'(rf_in_value), 64'h11);
      #1;
      chk("dup_ready1", 64'(req_ready), 64'b010);
      step();
      req_valid = '0;
      chk("dup_we1", 64'(rf_we), 64'd1);
      chk("dup_val1", 64'(rf_in_value), 64'h22);
      step();
      chk("dup_read_x7", 64'(rf[7]), 64'h22);

      // Reset right after an accept discards the staged write.
      set_req(0, 1, 5'd9, 32'hAA);
      step();
      req_valid = '0;
      step();
      chk("pre_read_x9", 64'(rf[9]), 64'hAA);
      set_req(0, 1, 5'd9, 32'h55);
      step();
      req_valid = '0;
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 64'(rf_we), 64'd0);
      step();
      chk("post_rst_we", 64'(rf_we), 64'd0);
      chk("post_rst_mask", 64'(pending_mask), 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_x9", 64'(rf[9]), 64'hAA);

      step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
